lfsr_checker: RTL and testbench

Serial self-synchronising checker for the XNOR-feedback Fibonacci LFSR bit streams that drive the modulator dither path. It loads its shift register from the incoming bits, verifies a run of correct predictions, then free-runs and counts mismatches. It sits on the dither BIST/debug tap, so a corrupted or stuck dither source is caught on silicon and in simulation.

---
 rtl/lfsr_checker_pkg.sv | 18 +
 rtl/lfsr_checker_errcnt.sv | 27 ++
 rtl/lfsr_checker.sv | 138 +++++++++++++
 tb/tb_lfsr_checker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_checker_pkg.sv
// Shared types and helpers for the dither-path LFSR stream checker.
// State encodings and the width of the saturating mismatch counter live here.
package lfsr_checker_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam int unsigned ERR_CNT_BITS = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [ERR_CNT_BITS-1:0] sat_inc(input logic [ERR_CNT_BITS-1:0] v);
      return (v == '1) ? v : v + ERR_CNT_BITS'(1);
   endfunction

endpackage

// File: rtl/lfsr_checker_errcnt.sv
// Saturating mismatch counter with synchronous clear.
// A clear coinciding with a counted error leaves the count at one.
module lfsr_checker_errcnt
   import lfsr_checker_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    i_inc,
   input  logic                    i_clr,
   output logic [ERR_CNT_BITS-1:0] o_cnt
);

   logic [ERR_CNT_BITS-1:0] r_cnt;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= i_inc ? ERR_CNT_BITS'(1) : '0;
      end else if (i_inc) begin
         r_cnt <= sat_inc(r_cnt);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for XNOR Fibonacci LFSR streams: fills from the
// input, verifies LOCK_CNT predictions, then free-runs and counts mismatches.
module lfsr_checker
   import lfsr_checker_pkg::*;
#(
   parameter int unsigned LEN      = 20,
   parameter int unsigned TAP      = 16,
   parameter int unsigned LOCK_CNT = 32,
   parameter int unsigned WIN      = 256,
   parameter int unsigned ERR_MAX  = 8
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    bit_i,
   input  logic                    valid_i,
   input  logic                    clr_i,
   output logic                    locked_o,
   output logic                    err_pulse_o,
   output logic                    lock_lost_o,
   output logic [ERR_CNT_BITS-1:0] err_cnt_o
);

   localparam int unsigned FILL_W  = $clog2(LEN);
   localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned WBITS_W = $clog2(WIN);
   localparam int unsigned WERR_W  = $clog2(ERR_MAX + 1);

   state_t               r_state;
   logic [LEN-1:0]       r_sr;
   logic [FILL_W-1:0]    r_fill_cnt;
   logic [MATCH_W-1:0]   r_match_cnt;
   logic [WBITS_W-1:0]   r_win_bits;
   logic [WERR_W-1:0]    r_win_err;
   logic                 r_locked;
   logic                 r_err_pulse;
   logic                 r_lock_lost;

   logic                 w_pred;
   logic                 w_miss;
   logic                 w_lockup;
   logic                 w_count_err;
   logic                 w_win_wrap;
   logic                 w_loss;
   logic [WERR_W-1:0]    w_win_err_nxt;

   assign w_pred        = r_sr[LEN-1] ~^ r_sr[TAP];
   assign w_miss        = bit_i ^ w_pred;
   assign w_lockup      = &r_sr;
   assign w_count_err   = valid_i && (r_state == ST_LOCKED) && w_miss;
   assign w_win_err_nxt = r_win_err + WERR_W'(1);
   // WIN is a power of two, so the window ends when the bit counter is all ones.
   assign w_win_wrap    = (r_win_bits == '1);
   assign w_loss        = w_count_err && (w_win_err_nxt == WERR_W'(ERR_MAX));

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state     <= ST_HUNT;
         r_sr        <= '0;
         r_fill_cnt  <= '0;
         r_match_cnt <= '0;
         r_win_bits  <= '0;
         r_win_err   <= '0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_lock_lost <= 1'b0;
      end else begin
         r_err_pulse <= 1'b0;
         r_lock_lost <= 1'b0;
         if (valid_i) begin
            case (r_state)
               ST_HUNT: begin
                  r_sr <= {r_sr[LEN-2:0], bit_i};
                  if (r_fill_cnt == FILL_W'(LEN - 1)) begin
                     r_state     <= ST_VERIFY;
                     r_fill_cnt  <= '0;
                     r_match_cnt <= '0;
                  end else begin
                     r_fill_cnt <= r_fill_cnt + FILL_W'(1);
                  end
               end

               ST_VERIFY: begin
                  r_sr <= {r_sr[LEN-2:0], bit_i};
                  // All-ones is the XNOR fixed point: it would "verify" forever.
                  if (w_lockup || w_miss) begin
                     r_state    <= ST_HUNT;
                     r_fill_cnt <= '0;
                  end else if (r_match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                     r_state    <= ST_LOCKED;
                     r_locked   <= 1'b1;
                     r_win_bits <= '0;
                     r_win_err  <= '0;
                  end else begin
                     r_match_cnt <= r_match_cnt + MATCH_W'(1);
                  end
               end

               ST_LOCKED: begin
                  r_sr        <= {r_sr[LEN-2:0], w_pred};
                  r_err_pulse <= w_miss;
                  r_win_bits  <= r_win_bits + WBITS_W'(1);
                  if (w_loss) begin
                     r_state     <= ST_HUNT;
                     r_fill_cnt  <= '0;
                     r_locked    <= 1'b0;
                     r_lock_lost <= 1'b1;
                     r_win_bits  <= '0;
                     r_win_err   <= '0;
                  end else if (w_win_wrap) begin
                     r_win_err <= '0;
                  end else if (w_miss) begin
                     r_win_err <= w_win_err_nxt;
                  end
               end

               default: begin
                  r_state    <= ST_HUNT;
                  r_fill_cnt <= '0;
                  r_locked   <= 1'b0;
               end
            endcase
         end
      end
   end

   lfsr_checker_errcnt u_errcnt (
      .clock   (clock),
      .reset_n (reset_n),
      .i_inc   (w_count_err),
      .i_clr   (clr_i),
      .o_cnt   (err_cnt_o)
   );

   assign locked_o    = r_locked;
   assign err_pulse_o = r_err_pulse;
   assign lock_lost_o = r_lock_lost;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed scenarios push expected outputs,
// a monitor pops and compares one entry per clock after each rising edge.
module tb_lfsr_checker;

   typedef struct packed {
      logic        locked;
      logic        pulse;
      logic        lost;
      logic [15:0] cnt;
   } exp_t;

   localparam int NEVER = 32'h3FFF_FFFF;

   logic        clock;
   logic        reset_n;
   logic        bit_i;
   logic        valid_i;
   logic        clr_i;
   logic        locked_o;
   logic        err_pulse_o;
   logic        lock_lost_o;
   logic [15:0] err_cnt_o;

   exp_t        exp_q[$];
   string       tag_q[$];
   int          idx_q[$];
   int          flip_at[$];
   int          clr_at[$];
   logic [19:0] g_sr;
   logic [15:0] exp_cnt;
   int          n_vec;
   int          n_miss;

   lfsr_checker #(
      .LEN      (20),
      .TAP      (16),
      .LOCK_CNT (32),
      .WIN      (256),
      .ERR_MAX  (8)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .bit_i       (bit_i),
      .valid_i     (valid_i),
      .clr_i       (clr_i),
      .locked_o    (locked_o),
      .err_pulse_o (err_pulse_o),
      .lock_lost_o (lock_lost_o),
      .err_cnt_o   (err_cnt_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Serial XNOR generator; 'flip' corrupts the emitted bit but not the state.
   task automatic lfsr_serial_gen(input logic flip, output logic b);
      logic t;
      t    = g_sr[19] ~^ g_sr[16];
      g_sr = {g_sr[18:0], t};
      b    = t ^ flip;
   endtask

   function automatic bit in_flip(input int k);
      foreach (flip_at[i]) if (flip_at[i] == k) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit in_clr(input int k);
      foreach (clr_at[i]) if (clr_at[i] == k) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic locked_at(input int k, input int lock_at, input int lost_at,
                                      input int relock_at);
      return ((k >= lock_at) && ((lost_at == 0) || (k < lost_at))) ||
             ((relock_at != 0) && (k >= relock_at));
   endfunction

   task automatic drive(input logic rn, input logic v, input logic b, input logic c,
                        input exp_t e, input string tag, input int idx);
      @(negedge clock);
      reset_n = rn;
      valid_i = v;
      bit_i   = b;
      clr_i   = c;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      idx_q.push_back(idx);
   endtask

   task automatic do_reset(input string tag, input int ncyc);
      exp_t e;
      e       = '0;
      exp_cnt = '0;
      for (int i = 0; i < ncyc; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, e, tag, i);
   endtask

   // k counts valid bits from 1 within this call; lock_at=0 means already locked.
   task automatic run_stream(input string tag, input int nbits, input int lock_at,
                             input int lost_at, input int relock_at,
                             input bit ones, input bit gap);
      logic b, fl, cl, lk, lk_prev, pl;
      exp_t e;
      lk_prev = locked_at(0, lock_at, lost_at, relock_at);
      for (int k = 1; k <= nbits; k++) begin
         fl = in_flip(k);
         cl = in_clr(k);
         if (ones) b = 1'b1;
         else lfsr_serial_gen(fl, b);
         lk = locked_at(k, lock_at, lost_at, relock_at);
         pl = fl && lk_prev;
         if (cl) exp_cnt = pl ? 16'd1 : 16'd0;
         else if (pl && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         e.locked = lk;
         e.pulse  = pl;
         e.lost   = (k == lost_at);
         e.cnt    = exp_cnt;
         drive(1'b1, 1'b1, b, cl, e, tag, k);
         if (gap) begin
            e.pulse = 1'b0;
            e.lost  = 1'b0;
            drive(1'b1, 1'b0, ~b, 1'b0, e, {tag, "_idle"}, k);
         end
         lk_prev = lk;
      end
   endtask

   always @(posedge clock) begin
      exp_t  e;
      string t;
      int    idx;
      #1;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         t   = tag_q.pop_front();
         idx = idx_q.pop_front();
         n_vec++;
         if (locked_o !== e.locked || err_pulse_o !== e.pulse ||
             lock_lost_o !== e.lost || err_cnt_o !== e.cnt) begin
            n_miss++;
            $display("FAIL %s[%0d]: got locked=%b pulse=%b lost=%b cnt=%0d, required locked=%b pulse=%b lost=%b cnt=%0d",
                     t, idx, locked_o, err_pulse_o, lock_lost_o, err_cnt_o,
                     e.locked, e.pulse, e.lost, e.cnt);
         end
      end
   end

   initial begin
      n_vec   = 0;
      n_miss  = 0;
      reset_n = 1'b0;
      valid_i = 1'b0;
      bit_i   = 1'b0;
      clr_i   = 1'b0;
      exp_cnt = '0;
      g_sr    = 20'hA_BCDE;

      do_reset("reset", 3);

      g_sr = 20'hA_BCDE;
      run_stream("clean", 10000, 52, 0, 0, 1'b0, 1'b0);
      flip_at = '{50, 100, 150};
      run_stream("inject", 200, 0, 0, 0, 1'b0, 1'b0);
      flip_at = '{5, 15};
      clr_at  = '{5, 10};
      run_stream("clear", 30, 0, 0, 0, 1'b0, 1'b0);
      clr_at  = {};

      do_reset("reset_loss", 2);
      g_sr    = 20'hA_BCDE;
      flip_at = '{62, 72, 82, 92, 102, 112, 122, 132};
      run_stream("loss", 250, 52, 132, 184, 1'b0, 1'b0);

      do_reset("reset_win", 2);
      g_sr    = 20'hA_BCDE;
      flip_at = '{62, 72, 82, 92, 102, 112, 122, 352, 362, 372, 382, 392, 402, 412};
      run_stream("win_clear", 450, 52, 0, 0, 1'b0, 1'b0);

      do_reset("reset_edge", 2);
      g_sr    = 20'hA_BCDE;
      flip_at = '{62, 72, 82, 92, 102, 112, 122, 308};
      run_stream("win_edge", 400, 52, 308, 360, 1'b0, 1'b0);

      do_reset("reset_gated", 2);
      g_sr    = 20'hA_BCDE;
      flip_at = {};
      run_stream("gated", 60, 52, 0, 0, 1'b0, 1'b1);

      do_reset("reset_early", 2);
      g_sr    = 20'hA_BCDE;
      flip_at = '{30};
      run_stream("early", 100, 82, 0, 0, 1'b0, 1'b0);

      do_reset("reset_ones", 2);
      flip_at = {};
      run_stream("ones", 300, NEVER, 0, 0, 1'b1, 1'b0);

      do_reset("reset_pre", 2);
      g_sr    = 20'hA_BCDE;
      flip_at = '{60};
      run_stream("prereset", 60, 52, 0, 0, 1'b0, 1'b0);
      do_reset("mid_lock", 1);
      flip_at = {};
      run_stream("relock", 60, 52, 0, 0, 1'b0, 1'b0);

      @(negedge clock);
      valid_i = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
